// File: rtl/captura_operandos.sv
// Keypad operand capture: assembles two decimal operands (BCD + binary) from debounced key
// events and hands them downstream over a valid/ack handshake.
module captura_operandos #(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned BIN_W  = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         key_valid,
   input  logic [3:0]                   key_code,
   output logic                         key_ack,
   output logic [4*DIGITS-1:0]          entry_bcd,
   output logic [$clog2(DIGITS+1)-1:0]  entry_count,
   output logic [1:0]                   phase,
   output logic [BIN_W-1:0]             operand_a,
   output logic [BIN_W-1:0]             operand_b,
   output logic                         operands_valid,
   input  logic                         operands_ack
);

   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned MW = BIN_W + 4;

   localparam logic [3:0] KeyStar = 4'd10;
   localparam logic [3:0] KeyHash = 4'd11;

   typedef enum logic [1:0] {
      EntryA = 2'd0,
      EntryB = 2'd1,
      Ready  = 2'd2
   } phase_e;

   phase_e            phase_q, phase_d;
   logic              key_ack_q, key_ack_d;
   logic              busy_q, busy_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic [CW-1:0]     count_q, count_d;
   logic [BIN_W-1:0]  acc_q, acc_d;
   logic [BIN_W-1:0]  op_a_q, op_a_d;
   logic [BIN_W-1:0]  op_b_q, op_b_d;
   logic              valid_q, valid_d;

   logic              accept;
   logic [MW-1:0]     acc_mul;

   // busy_q blocks re-consumption of the same key until upstream drops key_valid.
   assign accept  = key_valid && !key_ack_q && !busy_q;
   assign acc_mul = MW'(acc_q) * MW'(10) + MW'(key_code);

   always_comb begin
      phase_d   = phase_q;
      key_ack_d = accept;
      busy_d    = busy_q;
      bcd_d     = bcd_q;
      count_d   = count_q;
      acc_d     = acc_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      valid_d   = valid_q;

      if (accept) begin
         busy_d = 1'b1;
      end else if (!key_valid) begin
         busy_d = 1'b0;
      end

      if (!(phase_q inside {EntryA, EntryB, Ready})) begin
         phase_d = EntryA;
      end

      if (phase_q == Ready && operands_ack) begin
         valid_d = 1'b0;
         phase_d = EntryA;
      end

      if (accept) begin
         if (key_code == KeyStar) begin
            bcd_d   = '0;
            count_d = '0;
            acc_d   = '0;
            op_a_d  = '0;
            op_b_d  = '0;
            valid_d = 1'b0;
            phase_d = EntryA;
         end else begin
            case (phase_q)
               EntryA, EntryB: begin
                  if (key_code < 4'd10) begin
                     if (count_q < CW'(DIGITS)) begin
                        bcd_d   = (bcd_q << 4) | BW'(key_code);
                        acc_d   = acc_mul[BIN_W-1:0];
                        count_d = count_q + 1'b1;
                     end
                  end else if (key_code == KeyHash) begin
                     bcd_d   = '0;
                     count_d = '0;
                     acc_d   = '0;
                     if (phase_q == EntryA) begin
                        op_a_d  = acc_q;
                        phase_d = EntryB;
                     end else begin
                        op_b_d  = acc_q;
                        valid_d = 1'b1;
                        phase_d = Ready;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= EntryA;
         key_ack_q <= 1'b0;
         busy_q    <= 1'b0;
         bcd_q     <= '0;
         count_q   <= '0;
         acc_q     <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         key_ack_q <= key_ack_d;
         busy_q    <= busy_d;
         bcd_q     <= bcd_d;
         count_q   <= count_d;
         acc_q     <= acc_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         valid_q   <= valid_d;
      end
   end

   assign key_ack        = key_ack_q;
   assign entry_bcd      = bcd_q;
   assign entry_count    = count_q;
   assign phase          = phase_q;
   assign operand_a      = op_a_q;
   assign operand_b      = op_b_q;
   assign operands_valid = valid_q;

endmodule

// File: tb/tb_captura_operandos.sv
// Directed bench for captura_operandos: table of key events with expected state, plus
// hand-written sequences for handshake hold, abort-with-ack and asynchronous reset.
module tb_captura_operandos;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_ack;
   logic [11:0] entry_bcd;
   logic [1:0]  entry_count;
   logic [1:0]  phase;
   logic [9:0]  operand_a;
   logic [9:0]  operand_b;
   logic        operands_valid;
   logic        operands_ack;

   int n_tests = 0;
   int n_fail  = 0;
   logic ack_prev = 1'b0;

   always #5 clk = ~clk;

   captura_operandos #(.DIGITS(3), .BIN_W(10)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .key_valid      (key_valid),
      .key_code       (key_code),
      .key_ack        (key_ack),
      .entry_bcd      (entry_bcd),
      .entry_count    (entry_count),
      .phase          (phase),
      .operand_a      (operand_a),
      .operand_b      (operand_b),
      .operands_valid (operands_valid),
      .operands_ack   (operands_ack)
   );

   typedef struct {
      bit          pre_ack;
      logic [3:0]  code;
      int unsigned cnt;
      int unsigned bcd;
      int unsigned ph;
      int unsigned a;
      int unsigned b;
      int unsigned v;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input bit pa, input logic [3:0] c, input int unsigned cnt,
                      input int unsigned bcd, input int unsigned ph, input int unsigned a,
                      input int unsigned b, input int unsigned v);
      vec_t t;
      t.pre_ack = pa; t.code = c; t.cnt = cnt; t.bcd = bcd;
      t.ph = ph; t.a = a; t.b = b; t.v = v;
      vecs.push_back(t);
   endtask

   // Presents a key at a negedge and returns at the negedge where key_ack is seen.
   task automatic send_key(input logic [3:0] c);
      int n = 0;
      key_valid = 1'b1;
      key_code  = c;
      do begin
         @(negedge clk);
         n++;
      end while (!key_ack && n < 8);
      chk("key_ack_seen", 32'(key_ack), 1);
      key_valid = 1'b0;
   endtask

   // Single-cycle ack pulses, checked on every ack seen.
   always @(negedge clk) begin
      if (key_ack) begin
         n_tests++;
         if (ack_prev) begin
            n_fail++;
            $display("FAIL ack_width: got 2+ cycle pulse expected 1");
         end
      end
      ack_prev = key_ack;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;

      //   pre  code cnt bcd    ph a    b   v
      add(0,  1,   1, 'h001, 0, 0,   0,  0);
      add(0,  2,   2, 'h012, 0, 0,   0,  0);
      add(0,  3,   3, 'h123, 0, 0,   0,  0);
      add(0, 11,   0, 'h000, 1, 123, 0,  0);
      add(0,  4,   1, 'h004, 1, 123, 0,  0);
      add(0,  5,   2, 'h045, 1, 123, 0,  0);
      add(0, 11,   0, 'h000, 2, 123, 45, 1);
      add(1,  9,   1, 'h009, 0, 123, 45, 0);
      add(0,  9,   2, 'h099, 0, 123, 45, 0);
      add(0,  9,   3, 'h999, 0, 123, 45, 0);
      add(0,  7,   3, 'h999, 0, 123, 45, 0);
      add(0, 11,   0, 'h000, 1, 999, 45, 0);
      add(0, 11,   0, 'h000, 2, 999, 0,  1);
      add(0, 14,   0, 'h000, 2, 999, 0,  1);
      add(0,  3,   0, 'h000, 2, 999, 0,  1);
      add(0, 11,   0, 'h000, 2, 999, 0,  1);
      add(0, 10,   0, 'h000, 0, 0,   0,  0);
      add(0,  5,   1, 'h005, 0, 0,   0,  0);
      add(0, 11,   0, 'h000, 1, 5,   0,  0);
      add(0,  6,   1, 'h006, 1, 5,   0,  0);
      add(0, 11,   0, 'h000, 2, 5,   6,  1);

      rst_n = 1'b0;
      key_valid = 1'b0;
      key_code = 4'd0;
      operands_ack = 1'b0;
      #12;
      chk("rst_count", 32'(entry_count), 0);
      chk("rst_bcd", 32'(entry_bcd), 0);
      chk("rst_phase", 32'(phase), 0);
      chk("rst_valid", 32'(operands_valid), 0);
      chk("rst_ack", 32'(key_ack), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         if (vecs[i].pre_ack) begin
            operands_ack = 1'b1;
            @(negedge clk);
            operands_ack = 1'b0;
            chk("rel_valid", 32'(operands_valid), 0);
            chk("rel_phase", 32'(phase), 0);
         end
         send_key(vecs[i].code);
         chk($sformatf("v%0d_count", i), 32'(entry_count), vecs[i].cnt);
         chk($sformatf("v%0d_bcd", i), 32'(entry_bcd), vecs[i].bcd);
         chk($sformatf("v%0d_phase", i), 32'(phase), vecs[i].ph);
         chk($sformatf("v%0d_opa", i), 32'(operand_a), vecs[i].a);
         chk($sformatf("v%0d_opb", i), 32'(operand_b), vecs[i].b);
         chk($sformatf("v%0d_valid", i), 32'(operands_valid), vecs[i].v);
         @(negedge clk);
      end

      // '*' and operands_ack together in READY: abort wins.
      key_valid = 1'b1;
      key_code = 4'd10;
      operands_ack = 1'b1;
      @(negedge clk);
      operands_ack = 1'b0;
      chk("abort_ack", 32'(key_ack), 1);
      chk("abort_valid", 32'(operands_valid), 0);
      chk("abort_opa", 32'(operand_a), 0);
      chk("abort_opb", 32'(operand_b), 0);
      chk("abort_phase", 32'(phase), 0);
      key_valid = 1'b0;
      @(negedge clk);

      // key_valid held high for 5 cycles: one key only.
      acks = 0;
      key_valid = 1'b1;
      key_code = 4'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (key_ack) acks++;
      end
      key_valid = 1'b0;
      chk("hold_acks", 32'(acks), 1);
      chk("hold_count", 32'(entry_count), 1);
      chk("hold_bcd", 32'(entry_bcd), 'h003);
      @(negedge clk);

      send_key(4'd14);
      chk("inv_count", 32'(entry_count), 1);
      chk("inv_bcd", 32'(entry_bcd), 'h003);
      @(negedge clk);
      send_key(4'd11);
      chk("c3_opa", 32'(operand_a), 3);
      chk("c3_phase", 32'(phase), 1);
      @(negedge clk);
      send_key(4'd4);
      @(negedge clk);
      send_key(4'd2);
      chk("pre_rst_bcd", 32'(entry_bcd), 'h042);
      chk("pre_rst_count", 32'(entry_count), 2);
      @(negedge clk);

      // Asynchronous reset mid-entry with a key pending.
      key_valid = 1'b1;
      key_code = 4'd5;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_bcd", 32'(entry_bcd), 0);
      chk("arst_count", 32'(entry_count), 0);
      chk("arst_phase", 32'(phase), 0);
      chk("arst_opa", 32'(operand_a), 0);
      chk("arst_opb", 32'(operand_b), 0);
      chk("arst_valid", 32'(operands_valid), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("arst_no_ack", 32'(key_ack), 0);
      end
      key_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_count", 32'(entry_count), 0);
      chk("post_rst_phase", 32'(phase), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
